// File: rtl/dsp_flow_ctrl_pkg.sv
// ============================================================================
//  Module      : dsp_flow_ctrl_pkg
//  Description : Shared encodings for the DSP fetch sequencer / flow controller
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dsp_flow_ctrl_pkg;

    localparam int INST_WORD_LEN = 32;

    localparam logic [2:0] FLOW_NONE = 3'd0;
    localparam logic [2:0] FLOW_JMP  = 3'd1;
    localparam logic [2:0] FLOW_BEZ  = 3'd2;
    localparam logic [2:0] FLOW_BNEZ = 3'd3;
    localparam logic [2:0] FLOW_BEQ  = 3'd4;

    localparam logic [2:0] MEM_NONE   = 3'd0;
    localparam logic [2:0] MEM_LD     = 3'd1;
    localparam logic [2:0] MEM_LD_IMM = 3'd2;
    localparam logic [2:0] MEM_ST     = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HALTED   = 2'd3
    } flow_state_t;

    function automatic logic src_hit(input logic use_src, input logic [4:0] src, input logic [4:0] dest);
        return use_src & (src == dest);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dsp_branch_resolve.sv
// ============================================================================
//  Module      : dsp_branch_resolve
//  Description : Combinational branch decision and target for the execute stage
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_branch_resolve
    import dsp_flow_ctrl_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic            valid,
    input  logic [2:0]      flow_mode,
    input  logic [15:0]     data_s1,
    input  logic [15:0]     data_s2,
    input  logic [PC_W-1:0] jaddress,
    output logic            taken,
    output logic [PC_W-1:0] target
);

    logic w_cond;

    always_comb begin
        w_cond = 1'b0;
        case (flow_mode)
            FLOW_JMP:  w_cond = 1'b1;
            FLOW_BEZ:  w_cond = (data_s1 == 16'h0000);
            FLOW_BNEZ: w_cond = (data_s1 != 16'h0000);
            FLOW_BEQ:  w_cond = (data_s1 == data_s2);
            default:   w_cond = 1'b0;
        endcase
        taken  = valid & w_cond;
        target = jaddress;
    end

endmodule

`default_nettype wire

// File: rtl/dsp_flow_ctrl.sv
// ============================================================================
//  Module      : dsp_flow_ctrl
//  Description : PC owner, instruction fetch, branch redirect and load-use stall
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_flow_ctrl
    import dsp_flow_ctrl_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              INST_W   = INST_WORD_LEN,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] if_instr,
    output logic [PC_W-1:0]   if_pc,
    output logic              if_valid,
    input  logic [4:0]        id_reg_addr1,
    input  logic [4:0]        id_reg_addr2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic              ex_valid,
    input  logic [2:0]        ex_flow_mode,
    input  logic [2:0]        ex_mem_mode,
    input  logic [4:0]        ex_reg_dest,
    input  logic [15:0]       ex_data_s1,
    input  logic [15:0]       ex_data_s2,
    input  logic [PC_W-1:0]   ex_jaddress,
    output logic              id_hold,
    output logic              id_flush,
    output logic              ex_bubble,
    output logic              halted
);

    flow_state_t       state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] if_instr_q, if_instr_d;
    logic [PC_W-1:0]   if_pc_q, if_pc_d;
    logic              if_valid_q, if_valid_d;

    logic              taken;
    logic [PC_W-1:0]   target;
    logic              stall;

    dsp_branch_resolve #(
        .PC_W (PC_W)
    ) u_branch_resolve (
        .valid     (ex_valid),
        .flow_mode (ex_flow_mode),
        .data_s1   (ex_data_s1),
        .data_s2   (ex_data_s2),
        .jaddress  (ex_jaddress),
        .taken     (taken),
        .target    (target)
    );

    // Load in execute whose destination is read by the live decode instruction.
    assign stall = ex_valid & (ex_mem_mode == MEM_LD) & if_valid_q &
                   (src_hit(id_use1, id_reg_addr1, ex_reg_dest) |
                    src_hit(id_use2, id_reg_addr2, ex_reg_dest));

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        imem_req   = 1'b0;
        id_hold    = 1'b0;
        id_flush   = 1'b0;
        ex_bubble  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (taken) begin
                    id_flush   = 1'b1;
                    ex_bubble  = 1'b1;
                    pc_d       = target;
                    if_valid_d = 1'b0;
                    state_d    = halt ? ST_HALTED : ST_REDIRECT;
                end else if (halt) begin
                    if_valid_d = 1'b0;
                    state_d    = ST_HALTED;
                end else if (stall) begin
                    id_hold   = 1'b1;
                    ex_bubble = 1'b1;
                end else begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_d       = pc_q + PC_W'(1);
                    end else begin
                        if_valid_d = 1'b0;
                    end
                end
            end
            ST_REDIRECT: begin
                // if_instr still holds the word fetched before the branch resolved.
                id_flush = 1'b1;
                state_d  = halt ? ST_HALTED : ST_RUN;
            end
            ST_HALTED: begin
                if_valid_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            if_instr_q <= {INST_W{1'b0}};
            if_pc_q    <= {PC_W{1'b0}};
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign if_valid  = if_valid_q;
    assign halted    = (state_q == ST_HALTED);

endmodule

`default_nettype wire

// File: tb/tb_dsp_flow_ctrl.sv
// ============================================================================
//  Module      : tb_dsp_flow_ctrl
//  Description : Directed vector bench for dsp_flow_ctrl
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsp_flow_ctrl;
    import dsp_flow_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, halt, imem_ready;
    logic        imem_req, if_valid, id_hold, id_flush, ex_bubble, halted;
    logic [15:0] imem_addr, if_pc;
    logic [31:0] imem_rdata, if_instr;
    logic [4:0]  id_reg_addr1, id_reg_addr2, ex_reg_dest;
    logic        id_use1, id_use2, ex_valid;
    logic [2:0]  ex_flow_mode, ex_mem_mode;
    logic [15:0] ex_data_s1, ex_data_s2, ex_jaddress;

    logic        f0_req, f0_valid, f0_hold, f0_flush, f0_bubble, f0_halted;
    logic [15:0] f0_addr, f0_pc;
    logic [31:0] f0_rdata, f0_instr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_rdata = {16'hA5A5, imem_addr};
    assign f0_rdata   = {16'h5A5A, f0_addr};

    dsp_flow_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
        .id_reg_addr1(id_reg_addr1), .id_reg_addr2(id_reg_addr2), .id_use1(id_use1), .id_use2(id_use2),
        .ex_valid(ex_valid), .ex_flow_mode(ex_flow_mode), .ex_mem_mode(ex_mem_mode), .ex_reg_dest(ex_reg_dest),
        .ex_data_s1(ex_data_s1), .ex_data_s2(ex_data_s2), .ex_jaddress(ex_jaddress),
        .id_hold(id_hold), .id_flush(id_flush), .ex_bubble(ex_bubble), .halted(halted)
    );

    dsp_flow_ctrl #(.RESET_PC(16'h00F0)) dut_f0 (
        .clk(clk), .rst(rst), .start(start), .halt(halt),
        .imem_req(f0_req), .imem_addr(f0_addr), .imem_ready(imem_ready), .imem_rdata(f0_rdata),
        .if_instr(f0_instr), .if_pc(f0_pc), .if_valid(f0_valid),
        .id_reg_addr1(id_reg_addr1), .id_reg_addr2(id_reg_addr2), .id_use1(id_use1), .id_use2(id_use2),
        .ex_valid(ex_valid), .ex_flow_mode(ex_flow_mode), .ex_mem_mode(ex_mem_mode), .ex_reg_dest(ex_reg_dest),
        .ex_data_s1(ex_data_s1), .ex_data_s2(ex_data_s2), .ex_jaddress(ex_jaddress),
        .id_hold(f0_hold), .id_flush(f0_flush), .ex_bubble(f0_bubble), .halted(f0_halted)
    );

    typedef struct {
        logic        exv;
        logic [2:0]  flow;
        logic [2:0]  mem;
        logic [4:0]  dest;
        logic [15:0] s1;
        logic [15:0] s2;
        logic [15:0] ja;
        logic        u1;
        logic [4:0]  a1;
        logic        u2;
        logic [4:0]  a2;
        logic        eflush;
        logic        ehold;
        logic        ebub;
        logic        ereq;
        logic [15:0] eaddr;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic clear_ex();
        ex_valid = 1'b0; ex_flow_mode = FLOW_NONE; ex_mem_mode = MEM_NONE; ex_reg_dest = 5'd0;
        ex_data_s1 = 16'h0; ex_data_s2 = 16'h0; ex_jaddress = 16'h0;
        id_use1 = 1'b0; id_use2 = 1'b0; id_reg_addr1 = 5'd0; id_reg_addr2 = 5'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; halt = 1'b0; imem_ready = 1'b1;
        clear_ex();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    // Returns at the first negedge in RUN with pc = RESET_PC.
    task automatic start_run();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        exv flow       mem         d  s1       s2       ja       u1 a1 u2 a2  fl ho bu rq addr
        vecs[0]  = '{1, FLOW_BEQ,  MEM_NONE,   0, 16'h1234, 16'h1234, 16'h0040, 0, 0, 0, 0, 1, 0, 1, 0, 16'h0040};
        vecs[1]  = '{1, FLOW_BEQ,  MEM_NONE,   0, 16'h1234, 16'h1235, 16'h0040, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0002};
        vecs[2]  = '{1, FLOW_BNEZ, MEM_NONE,   0, 16'h0000, 16'h0000, 16'h0080, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0002};
        vecs[3]  = '{1, FLOW_BNEZ, MEM_NONE,   0, 16'h0007, 16'h0000, 16'h0100, 0, 0, 0, 0, 1, 0, 1, 0, 16'h0100};
        vecs[4]  = '{1, FLOW_BEZ,  MEM_NONE,   0, 16'h0000, 16'h0009, 16'h0040, 0, 0, 0, 0, 1, 0, 1, 0, 16'h0040};
        vecs[5]  = '{1, FLOW_BEZ,  MEM_NONE,   0, 16'h0003, 16'h0000, 16'h0040, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0002};
        vecs[6]  = '{1, FLOW_JMP,  MEM_NONE,   0, 16'h0000, 16'h0000, 16'h0200, 0, 0, 0, 0, 1, 0, 1, 0, 16'h0200};
        vecs[7]  = '{1, FLOW_NONE, MEM_NONE,   0, 16'h0000, 16'h0000, 16'h0200, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0002};
        vecs[8]  = '{1, FLOW_NONE, MEM_LD,     5, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 5, 0, 1, 1, 0, 16'h0001};
        vecs[9]  = '{1, FLOW_NONE, MEM_LD,     5, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 5, 0, 0, 0, 1, 16'h0002};
        vecs[10] = '{1, FLOW_NONE, MEM_LD,     5, 16'h0000, 16'h0000, 16'h0000, 1, 5, 0, 0, 0, 1, 1, 0, 16'h0001};
        vecs[11] = '{1, FLOW_NONE, MEM_LD_IMM, 5, 16'h0000, 16'h0000, 16'h0000, 1, 5, 0, 0, 0, 0, 0, 1, 16'h0002};
        vecs[12] = '{1, FLOW_NONE, MEM_ST,     5, 16'h0000, 16'h0000, 16'h0000, 1, 5, 1, 5, 0, 0, 0, 1, 16'h0002};
        vecs[13] = '{1, FLOW_NONE, MEM_LD,     0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 1, 1, 0, 16'h0001};
        vecs[14] = '{1, FLOW_JMP,  MEM_LD,     5, 16'h0000, 16'h0000, 16'h0300, 0, 0, 1, 5, 1, 0, 1, 0, 16'h0300};
        vecs[15] = '{1, 3'd7,      MEM_NONE,   0, 16'h0000, 16'h0000, 16'h0300, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0002};
        vecs[16] = '{0, FLOW_JMP,  MEM_LD,     5, 16'h0000, 16'h0000, 16'h0300, 0, 0, 1, 5, 0, 0, 0, 1, 16'h0002};
        vecs[17] = '{1, FLOW_NONE, MEM_LD,     5, 16'h0000, 16'h0000, 16'h0000, 1, 6, 1, 4, 0, 0, 0, 1, 16'h0002};

        // Reset state
        do_reset();
        #1;
        check("rst_addr", imem_addr, 16'h0000);
        check("rst_req", imem_req, 0);
        check("rst_valid", if_valid, 0);
        check("rst_instr", if_instr, 0);
        check("rst_ifpc", if_pc, 0);
        check("rst_ctl", {id_hold, id_flush, ex_bubble, halted}, 0);
        check("rst_f0_addr", f0_addr, 16'h00F0);
        check("rst_f0_ifpc", f0_pc, 0);

        // Sequential fetch from both reset vectors
        start_run();
        for (int k = 0; k < 4; k++) begin
            #1;
            check("fetch_addr", imem_addr, 16'(k));
            check("fetch_req", imem_req, 1);
            check("fetch_valid", if_valid, (k > 0) ? 1 : 0);
            if (k > 0) check("fetch_ifpc", if_pc, 16'(k - 1));
            check("fetch_f0_addr", f0_addr, 16'h00F0 + 16'(k));
            next_cycle();
        end
        #1;
        check("fetch_instr", if_instr, 32'hA5A50003);
        check("fetch_f0_instr", f0_instr, 32'h5A5A00F3);

        // Table: one execute-stage event against a live decode word at pc=1
        for (int v = 0; v < NVEC; v++) begin
            do_reset();
            start_run();
            next_cycle();
            ex_valid = vecs[v].exv; ex_flow_mode = vecs[v].flow; ex_mem_mode = vecs[v].mem;
            ex_reg_dest = vecs[v].dest; ex_data_s1 = vecs[v].s1; ex_data_s2 = vecs[v].s2;
            ex_jaddress = vecs[v].ja; id_use1 = vecs[v].u1; id_reg_addr1 = vecs[v].a1;
            id_use2 = vecs[v].u2; id_reg_addr2 = vecs[v].a2;
            #1;
            check($sformatf("v%0d_flush", v), id_flush, vecs[v].eflush);
            check($sformatf("v%0d_hold", v), id_hold, vecs[v].ehold);
            check($sformatf("v%0d_bubble", v), ex_bubble, vecs[v].ebub);
            check($sformatf("v%0d_req", v), imem_req, vecs[v].ereq);
            next_cycle();
            clear_ex();
            #1;
            check($sformatf("v%0d_addr2", v), imem_addr, vecs[v].eaddr);
            check($sformatf("v%0d_flush2", v), id_flush, vecs[v].eflush);
            check($sformatf("v%0d_req2", v), imem_req, !vecs[v].eflush);
            check($sformatf("v%0d_hold2", v), id_hold, 0);
            next_cycle();
            #1;
            check($sformatf("v%0d_addr3", v), imem_addr,
                  vecs[v].eflush ? vecs[v].ja : vecs[v].eaddr + 16'd1);
            check($sformatf("v%0d_req3", v), imem_req, 1);
        end

        // PC wrap: jump to 0xFFFF, the following fetch goes to 0x0000
        do_reset();
        start_run();
        next_cycle();
        ex_valid = 1'b1; ex_flow_mode = FLOW_JMP; ex_jaddress = 16'hFFFF;
        next_cycle();
        clear_ex();
        next_cycle();
        #1;
        check("wrap_addr_ffff", imem_addr, 16'hFFFF);
        check("wrap_valid0", if_valid, 0);
        next_cycle();
        #1;
        check("wrap_addr_0", imem_addr, 16'h0000);
        check("wrap_ifpc", if_pc, 16'hFFFF);
        check("wrap_valid1", if_valid, 1);

        // Memory not ready for three cycles
        do_reset();
        start_run();
        next_cycle();
        imem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("nrdy_addr", imem_addr, 16'h0001);
            check("nrdy_req", imem_req, 1);
            if (k > 0) check("nrdy_valid", if_valid, 0);
            next_cycle();
            if (k == 2) imem_ready = 1'b1;
        end
        #1;
        check("nrdy_resume_addr", imem_addr, 16'h0002);
        check("nrdy_resume_valid", if_valid, 1);
        check("nrdy_resume_ifpc", if_pc, 16'h0001);

        // Halt is sticky and ignores start
        do_reset();
        start_run();
        next_cycle();
        halt = 1'b1;
        next_cycle();
        halt = 1'b0;
        #1;
        check("halt_halted", halted, 1);
        check("halt_req", imem_req, 0);
        check("halt_valid", if_valid, 0);
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        #1;
        check("halt_start_halted", halted, 1);
        check("halt_start_req", imem_req, 0);
        next_cycle();
        #1;
        check("halt_sticky", halted, 1);

        // Reset while in REDIRECT
        do_reset();
        start_run();
        next_cycle();
        ex_valid = 1'b1; ex_flow_mode = FLOW_JMP; ex_jaddress = 16'h0555;
        next_cycle();
        clear_ex();
        #1;
        check("redir_flush", id_flush, 1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        check("redir_rst_addr", imem_addr, 16'h0000);
        check("redir_rst_req", imem_req, 0);
        check("redir_rst_flush", id_flush, 0);
        check("redir_rst_valid", if_valid, 0);
        check("redir_rst_f0_addr", f0_addr, 16'h00F0);
        next_cycle();
        #1;
        check("redir_rst_idle", {imem_req, imem_addr}, {1'b0, 16'h0000});
        start_run();
        #1;
        check("redir_restart_addr", imem_addr, 16'h0000);
        check("redir_restart_req", imem_req, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dsp_flow_ctrl.md
Name: dsp_flow_ctrl

Overview:
- Fetch sequencer and flow controller for the DSP receiver core.
- Owns the program counter and issues instruction-memory requests.
- Registers the fetched word for DSPDecode.
- Resolves JMP/BEZ/BNEZ/BEQ from execute-stage operands, and inserts flushes and load-use stalls into the decode/execute pipeline registers.

Parameters:
- PC_W, 16, program counter / jump address width (word addressed).
- INST_W, 32, instruction width; equals `INST_WORD_LEN.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  leave IDLE and begin fetching.
- halt  in  1  stop fetching; sticky until rst.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_ready  in  1  memory accepts req; imem_rdata valid same cycle.
- imem_rdata  in  INST_W  fetched word.
- if_instr  out  INST_W  registered instruction to decode.
- if_pc  out  PC_W  address of if_instr.
- if_valid  out  1  if_instr is live.
- id_reg_addr1, id_reg_addr2  in  5  decode source registers.
- id_use1, id_use2  in  1  decode actually reads addr1/addr2.
- ex_valid  in  1  execute-stage instruction is live.
- ex_flow_mode  in  3  `FLOW_* of execute instruction.
- ex_mem_mode  in  3  `MEM_* of execute instruction.
- ex_reg_dest  in  5  execute destination register.
- ex_data_s1, ex_data_s2  in  16  execute operands.
- ex_jaddress  in  PC_W  execute branch target.
- id_hold  out  1  decode/ID-EX register must hold.
- id_flush  out  1  kill instruction in decode.
- ex_bubble  out  1  load NOP into ID-EX register.
- halted  out  1  state is HALTED.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0.
  - All outputs 0 except imem_addr=RESET_PC.
  - rst mid-operation discards any pending redirect or stall.
- States: IDLE, RUN, REDIRECT, HALTED.
- IDLE: imem_req=0. start=1 -> RUN next cycle.
- RUN: imem_req = ~stall & ~taken.
  - Fetch when imem_req & imem_ready: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+1.
  - pc wraps 16'hFFFF->16'h0000.
  - imem_req & ~imem_ready: pc holds, if_valid<=0 (bubble). The request stays asserted until accepted.
- taken is combinational. It is forced 0 when ex_valid=0.
  - FLOW_JMP: 1.
  - FLOW_BEZ: ex_data_s1==0.
  - FLOW_BNEZ: ex_data_s1!=0.
  - FLOW_BEQ: ex_data_s1==ex_data_s2.
  - FLOW_NONE or other codes: 0.
- taken in RUN, same cycle: id_flush=1, ex_bubble=1, no fetch. Next cycle: pc<=ex_jaddress, if_valid<=0, state->REDIRECT.
- REDIRECT: one bubble cycle. imem_req=0, id_flush=1 (kills the stale if_instr), then state->RUN. Taken-branch penalty is 3 cycles.
- stall (load-use) = ex_valid & ex_mem_mode==`MEM_LD & if_valid & ((id_use1 & id_reg_addr1==ex_reg_dest) | (id_use2 & id_reg_addr2==ex_reg_dest)).
  - While stalled: id_hold=1, ex_bubble=1, pc/if_instr/if_valid hold, imem_req=0.
  - Lasts exactly 1 cycle, because the load then leaves execute.
- Priority: rst > taken > halt > stall > fetch. taken and stall together: taken wins, and id_hold=0.
- halt in RUN/IDLE/REDIRECT: state->HALTED next cycle (a simultaneous taken still flushes first).
  - HALTED: imem_req=0, if_valid=0, halted=1, start ignored. Exit only by rst.
- MEM_LD_IMM and MEM_ST never cause a stall.
- Register 0 is not special-cased.

Decomposition:
- `FLOW_*, `MEM_*, `INST_WORD_LEN and the state encodings (2-bit) live in definitions.v.
- Sub-module dsp_branch_resolve (combinational taken/target from flow_mode and operands) is natural; it is reused by the verification model.

Test Plan:
- Reset then start, imem_ready=1, rdata=pc-tagged words:
  - imem_addr 0,1,2,3 on successive cycles.
  - if_pc lags by 1, if_valid=1 from cycle after first fetch.
  - RESET_PC=16'h00F0 build starts at 0xF0.
- ex_valid=1, FLOW_BEQ, s1=s2=16'h1234, jaddress=16'h0040:
  - id_flush=1 for 2 cycles, ex_bubble=1.
  - next fetched address 0x0040; 3-cycle penalty.
- FLOW_BNEZ with s1=0: no flush, fetch continues at pc+1.
- FLOW_BEZ with s1=0: redirect as above.
- ex MEM_LD dest=5, decode id_use2=1, addr2=5:
  - exactly 1 cycle of id_hold=1, ex_bubble=1, imem_req=0; pc unchanged.
  - Same with id_use2=0: no stall.
- Stall and FLOW_JMP in same cycle: redirect taken, id_hold=0. pc=0xFFFF fetch wraps to 0x0000.
- imem_ready low 3 cycles: imem_addr held, if_valid=0 those cycles.
- halt mid-run: halted=1 next cycle, imem_req=0, start ignored.
- rst during REDIRECT: returns to IDLE, pc=RESET_PC.
